// File: rtl/input_selector_sequencer.sv
// Steps input_selector_block through a table of complete lane-selection words,
// one entry per accepted valid/ready handshake, with optional wrap-around.
module input_selector_sequencer #(
  parameter int DATA_WIDTH      = 4,
  parameter int MAIN_INPUTS     = 16,
  parameter int REGS_INPUTS     = 64,
  parameter int OUTPUTS         = 4,
  parameter int OUTPUTS_PER_BUS = 4,
  parameter int DEPTH           = 8,
  localparam int MAIN_W  = $clog2(MAIN_INPUTS),
  localparam int REGS_W  = $clog2(REGS_INPUTS),
  // DATA_WIDTH is carried only for parameter parity with the selector
  localparam int LANES   = OUTPUTS * OUTPUTS_PER_BUS + 0 * DATA_WIDTH,
  localparam int LANE_W  = $clog2(LANES),
  localparam int SEL_W   = REGS_W + MAIN_W + 1,
  localparam int SELEC_W = LANES * SEL_W,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_entry,
  input  logic [LANE_W-1:0]  cfg_lane,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               start,
  input  logic [IDX_W:0]     num_steps,
  input  logic               loop,
  input  logic               abort,
  input  logic               out_ready,
  output logic [SELEC_W-1:0] wSelec,
  output logic               wBusy,
  output logic               out_valid,
  output logic [IDX_W-1:0]   step,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                           state_q, state_d;
  logic [LANES-1:0][SEL_W-1:0]      tbl_q [DEPTH];
  logic [SELEC_W-1:0]               wSelec_q, wSelec_d;
  logic                             busy_q, busy_d;
  logic                             valid_q, valid_d;
  logic [IDX_W-1:0]                 step_q, step_d;
  logic                             done_q, done_d;
  logic                             cfgErr_q, cfgErr_d;
  logic [IDX_W:0]                   numSteps_q, numSteps_d;
  logic                             loop_q, loop_d;
  logic                             tableWe;
  logic                             entryOk;
  logic                             stepsOk;
  logic                             lastStep;

  always_comb begin
    state_d    = state_q;
    wSelec_d   = wSelec_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    step_d     = step_q;
    numSteps_d = numSteps_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    cfgErr_d   = 1'b0;
    tableWe    = 1'b0;
    entryOk    = (32'(cfg_entry) < 32'(DEPTH));
    stepsOk    = (num_steps != '0) && (32'(num_steps) <= 32'(DEPTH));
    lastStep   = ({1'b0, step_q} == (numSteps_q - 1'b1));

    if (cfg_we) begin
      if ((state_q == RUN) || !entryOk) cfgErr_d = 1'b1;
      else                              tableWe  = 1'b1;
    end

    // table reads always see the pre-edge contents, so a same-cycle write
    // to entry 0 only shows up on a later start
    case (state_q)
      IDLE: begin
        if (start) begin
          if (stepsOk) begin
            state_d    = RUN;
            numSteps_d = num_steps;
            loop_d     = loop;
            step_d     = '0;
            wSelec_d   = tbl_q[0];
            valid_d    = 1'b1;
            busy_d     = 1'b1;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (out_ready) begin
          if (!lastStep) begin
            step_d   = step_q + 1'b1;
            wSelec_d = tbl_q[step_q + 1'b1];
          end else if (loop_q) begin
            step_d   = '0;
            wSelec_d = tbl_q[0];
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      wSelec_q   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      step_q     <= '0;
      done_q     <= 1'b0;
      cfgErr_q   <= 1'b0;
      numSteps_q <= '0;
      loop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wSelec_q   <= wSelec_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      done_q     <= done_d;
      cfgErr_q   <= cfgErr_d;
      numSteps_q <= numSteps_d;
      loop_q     <= loop_d;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int e = 0; e < DEPTH; e++) tbl_q[e] <= '0;
    end else if (tableWe) begin
      tbl_q[cfg_entry][cfg_lane] <= cfg_sel;
    end
  end

  assign wSelec    = wSelec_q;
  assign wBusy     = busy_q;
  assign out_valid = valid_q;
  assign step      = step_q;
  assign done      = done_q;
  assign cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_input_selector_sequencer.sv
// Bench for input_selector_sequencer: directed vector table, reset corner
// cases, then randomized traffic against a behavioural playlist model.
module tb_input_selector_sequencer;

  localparam int DEPTH   = 8;
  localparam int LANES   = 16;
  localparam int SEL_W   = 11;
  localparam int SELEC_W = LANES * SEL_W;

  logic               clk;
  logic               reset_L;
  logic               cfg_we;
  logic [2:0]         cfg_entry;
  logic [3:0]         cfg_lane;
  logic [SEL_W-1:0]   cfg_sel;
  logic               start;
  logic [3:0]         num_steps;
  logic               loop;
  logic               abort;
  logic               out_ready;
  logic [SELEC_W-1:0] wSelec;
  logic               wBusy;
  logic               out_valid;
  logic [2:0]         step;
  logic               done;
  logic               cfg_err;

  int checks = 0;
  int errors = 0;

  input_selector_sequencer dut (
    .clk(clk), .reset_L(reset_L), .cfg_we(cfg_we), .cfg_entry(cfg_entry),
    .cfg_lane(cfg_lane), .cfg_sel(cfg_sel), .start(start), .num_steps(num_steps),
    .loop(loop), .abort(abort), .out_ready(out_ready), .wSelec(wSelec),
    .wBusy(wBusy), .out_valid(out_valid), .step(step), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a table of lane words plus a "playlist" position
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  logic [SEL_W-1:0]   mTab [DEPTH][LANES];
  int                 mMode, mPos, mLen;
  bit                 mWrap, mValid, mDone, mErr;
  logic [SELEC_W-1:0] mSel;

  function automatic logic [SELEC_W-1:0] entryWord(int e);
    logic [SELEC_W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*SEL_W +: SEL_W] = mTab[e][l];
    return r;
  endfunction

  task automatic modelReset();
    for (int e = 0; e < DEPTH; e++)
      for (int l = 0; l < LANES; l++) mTab[e][l] = '0;
    mMode = M_IDLE; mPos = 0; mLen = 0; mWrap = 0;
    mValid = 0; mDone = 0; mErr = 0; mSel = '0;
  endtask

  task automatic modelEdge();
    int oldMode;
    oldMode = mMode;
    mDone = 0;
    mErr  = 0;
    if (oldMode == M_IDLE && start) begin
      if (int'(num_steps) >= 1 && int'(num_steps) <= DEPTH) begin
        mLen = int'(num_steps); mWrap = loop; mPos = 0;
        mSel = entryWord(0); mMode = M_RUN; mValid = 1;
      end else begin
        mErr = 1;
      end
    end else if (oldMode == M_RUN) begin
      if (abort) begin
        mMode = M_IDLE; mValid = 0;
      end else if (out_ready) begin
        if (mPos + 1 < mLen) begin
          mPos = mPos + 1; mSel = entryWord(mPos);
        end else if (mWrap) begin
          mPos = 0; mSel = entryWord(0);
        end else begin
          mMode = M_DONE; mValid = 0; mDone = 1;
        end
      end
    end else if (oldMode == M_DONE) begin
      mMode = M_IDLE;
    end
    if (cfg_we) begin
      if (oldMode == M_RUN) mErr = 1;
      else mTab[cfg_entry][cfg_lane] = cfg_sel;
    end
  endtask

  task automatic checkVal(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel(string name);
    checkVal(name, {out_valid, wBusy, step, done, cfg_err, wSelec},
             {mValid, mValid, 3'(mPos), mDone, mErr, mSel});
  endtask

  task automatic tick(string name);
    modelEdge();
    @(posedge clk);
    #1;
    checkModel(name);
  endtask

  typedef struct {
    logic       we;
    logic [2:0] entry;
    logic [3:0] lane;
    logic [10:0] sel;
    logic       st;
    logic [3:0] n;
    logic       lp;
    logic       ab;
    logic       rdy;
    logic       eValid;
    logic [2:0] eStep;
    logic       eDone;
    logic       eErr;
    logic [10:0] eL0;
    logic [10:0] eL15;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [2:0] entry, logic [3:0] lane, logic [10:0] sel,
                              logic st, logic [3:0] n, logic lp, logic ab, logic rdy,
                              logic eValid, logic [2:0] eStep, logic eDone, logic eErr,
                              logic [10:0] eL0, logic [10:0] eL15);
    vec_t v;
    v.we = we; v.entry = entry; v.lane = lane; v.sel = sel; v.st = st; v.n = n;
    v.lp = lp; v.ab = ab; v.rdy = rdy; v.eValid = eValid; v.eStep = eStep;
    v.eDone = eDone; v.eErr = eErr; v.eL0 = eL0; v.eL15 = eL15;
    return v;
  endfunction

  task automatic applyStimulus(vec_t v);
    cfg_we = v.we; cfg_entry = v.entry; cfg_lane = v.lane; cfg_sel = v.sel;
    start = v.st; num_steps = v.n; loop = v.lp; abort = v.ab; out_ready = v.rdy;
  endtask

  task automatic clearInputs();
    cfg_we = 0; cfg_entry = 0; cfg_lane = 0; cfg_sel = 0;
    start = 0; num_steps = 0; loop = 0; abort = 0; out_ready = 0;
  endtask

  initial begin
    // we e  ln sel  st n lp ab rdy | valid step done err lane0 lane15
    vecs.push_back(mk(1, 0, 0,  11'h2E0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 11'h000, 11'h000));
    vecs.push_back(mk(1, 0, 15, 11'h52B, 0, 0, 0, 0, 0,  0, 0, 0, 0, 11'h000, 11'h000));
    vecs.push_back(mk(1, 1, 0,  11'h111, 0, 0, 0, 0, 0,  0, 0, 0, 0, 11'h000, 11'h000));
    vecs.push_back(mk(1, 2, 0,  11'h222, 0, 0, 0, 0, 0,  0, 0, 0, 0, 11'h000, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       1, 1, 0, 0, 1,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  0, 0, 1, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  0, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       1, 3, 0, 0, 0,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  1, 1, 0, 0, 11'h111, 11'h000));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  1, 1, 0, 0, 11'h111, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  1, 2, 0, 0, 11'h222, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  0, 2, 1, 0, 11'h222, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 0,  0, 2, 0, 0, 11'h222, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       1, 0, 0, 0, 0,  0, 2, 0, 1, 11'h222, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       1, 9, 0, 0, 0,  0, 2, 0, 1, 11'h222, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       1, 2, 1, 0, 1,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  1, 1, 0, 0, 11'h111, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 1,  1, 1, 0, 0, 11'h111, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 1,  0, 1, 0, 0, 11'h111, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 0, 0,  0, 1, 0, 0, 11'h111, 11'h000));
    vecs.push_back(mk(0, 0, 0,  0,       1, 1, 0, 0, 0,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(1, 0, 0,  11'h7FF, 1, 1, 0, 0, 0,  1, 0, 0, 1, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 0,  0, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       1, 1, 0, 0, 0,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 0,  0, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(1, 0, 0,  11'h0AB, 1, 1, 0, 0, 0,  1, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 0,  0, 0, 0, 0, 11'h2E0, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       1, 1, 0, 0, 0,  1, 0, 0, 0, 11'h0AB, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 0,  0, 0, 0, 0, 11'h0AB, 11'h52B));
    vecs.push_back(mk(0, 0, 0,  0,       0, 0, 0, 1, 0,  0, 0, 0, 0, 11'h0AB, 11'h52B));

    clearInputs();
    modelReset();
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    #1;
    checkVal("reset_before_clock", {out_valid, wBusy, step, done, cfg_err, wSelec}, '0);
    #20;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    checkModel("idle_after_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick($sformatf("vec%0d_model", i));
      checkVal($sformatf("vec%0d", i),
               {out_valid, wBusy, step, done, cfg_err, wSelec[10:0], wSelec[175:165]},
               {vecs[i].eValid, vecs[i].eValid, vecs[i].eStep, vecs[i].eDone,
                vecs[i].eErr, vecs[i].eL0, vecs[i].eL15});
    end

    // reset pulled mid-run at step 2, then confirm the table was cleared
    clearInputs();
    start = 1; num_steps = 4; out_ready = 1;
    tick("midrun_start");
    start = 0;
    tick("midrun_step1");
    tick("midrun_step2");
    checkVal("midrun_at_step2", {29'd0, step}, 32'd2);
    #3 reset_L = 1'b0;
    modelReset();
    #1;
    checkVal("midrun_async_clear", {out_valid, wBusy, step, done, cfg_err, wSelec}, '0);
    @(posedge clk);
    #1;
    checkVal("midrun_held_clear", {out_valid, wBusy, step, done, cfg_err, wSelec}, '0);
    reset_L = 1'b1;
    out_ready = 0;
    start = 1; num_steps = 1;
    tick("after_reset_start");
    checkVal("after_reset_table_zero", {out_valid, wSelec}, {1'b1, {SELEC_W{1'b0}}});
    clearInputs();
    tick("after_reset_idle");

    for (int c = 0; c < 2000; c++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_entry = 3'($urandom_range(0, DEPTH - 1));
      cfg_lane  = 4'($urandom_range(0, LANES - 1));
      cfg_sel   = 11'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      num_steps = 4'($urandom_range(0, 9));
      loop      = ($urandom_range(0, 2) == 0);
      abort     = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_selector_sequencer.md
Name: input_selector_sequencer

Overview:
- Programmable controller that drives the 176-bit `wSelec` configuration bus and `wBusy` of `input_selector_block`.
- Holds a table of DEPTH complete selection configurations and steps through them one entry per accepted handshake, optionally looping.
- Sits between the host configuration interface and the selector; a downstream consumer paces stepping via a valid/ready handshake.

Parameters:
- DATA_WIDTH, 4, lane data width; passed through for consistency, unused internally.
- MAIN_INPUTS, 16, main data inputs; MAIN_W = clog2(MAIN_INPUTS) = 4.
- REGS_INPUTS, 64, register inputs; REGS_W = clog2(REGS_INPUTS) = 6.
- OUTPUTS, 4, output buses.
- OUTPUTS_PER_BUS, 4, lanes per bus. Derived: LANES = OUTPUTS*OUTPUTS_PER_BUS = 16; SEL_W = REGS_W+MAIN_W+1 = 11; SELEC_W = LANES*SEL_W = 176.
- DEPTH, 8, table entries; IDX_W = clog2(DEPTH) = 3.

Ports:
- clk  in  1  clock, rising edge.
- reset_L  in  1  asynchronous reset, active low.
- cfg_we  in  1  table write strobe.
- cfg_entry  in  IDX_W  entry written.
- cfg_lane  in  clog2(LANES)  lane written.
- cfg_sel  in  SEL_W  lane selection word.
- start  in  1  begin sequence.
- num_steps  in  IDX_W+1  entries to play, legal 1..DEPTH.
- loop  in  1  wrap to entry 0 after the last entry.
- abort  in  1  stop sequence.
- out_ready  in  1  consumer accepts current configuration.
- wSelec  out  SELEC_W  configuration to the selector.
- wBusy  out  1  selector busy flag.
- out_valid  out  1  wSelec holds a live entry.
- step  out  IDX_W  current entry index.
- done  out  1  one-cycle end-of-sequence pulse.
- cfg_err  out  1  one-cycle illegal-request pulse.

Behaviour:
- Lane i occupies wSelec[(i+1)*SEL_W-1 : i*SEL_W] as {regs_idx[REGS_W-1:0], main_idx[MAIN_W-1:0], origin}. origin=0 selects main; origin=1 selects regs. The sequencer copies table words verbatim and never interprets them.
- Reset (reset_L=0, asynchronous): state IDLE; wSelec, wBusy, out_valid, step, done, cfg_err = 0; all table words = 0; latched num_steps/loop = 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- Table writes:
  - In IDLE or DONE, cfg_we writes cfg_sel to table[cfg_entry][cfg_lane] at the clock edge.
  - In RUN, cfg_we is ignored and cfg_err pulses the next cycle.
  - cfg_entry >= DEPTH is ignored and pulses cfg_err.
- IDLE behaviour:
  - start with 1 <= num_steps <= DEPTH: latch num_steps and loop. Next cycle: RUN, step=0, wSelec=table[0], out_valid=1, wBusy=1. Latency is 1 cycle.
  - start with num_steps=0 or >DEPTH: stay IDLE, cfg_err pulse.
  - start and cfg_we together: both take effect. The write lands before the table[0] read only if it targets an entry other than 0; a write to entry 0 is seen on the following start.
- RUN behaviour:
  - While out_valid && !out_ready, wSelec and step are held stable.
  - On out_valid && out_ready at an edge, if step < N-1 (N = latched num_steps): step+1, wSelec = table[step+1].
  - If step == N-1 and loop=1: step=0, wSelec=table[0], with no bubble.
  - If step == N-1 and loop=0: go to DONE; out_valid=0, wBusy=0, done=1; wSelec holds the last entry.
  - start in RUN is ignored, with no error.
  - abort in RUN has priority over the handshake. Next cycle: IDLE, out_valid=0, wBusy=0, done=0; wSelec and step hold.
- DONE: lasts exactly one cycle (done=1), then unconditionally IDLE. start in DONE is ignored.
- abort in IDLE or DONE has no effect.
- reset_L asserted mid-RUN clears everything asynchronously, with no done pulse.

Test Plan:
- Reset -> all outputs 0 immediately on reset_L low, including before the first clock edge; after release, state IDLE and step=0.
- Write entry0 lane0 = 11'h2E0 (regs 0x17, main 0, origin 0) and lane15 = 11'h52B; start, num_steps=1, loop=0, out_ready=1 ->
  - cycle+1: out_valid=1, wBusy=1, wSelec[10:0]=11'h2E0, wSelec[175:165]=11'h52B.
  - cycle+2: done=1, out_valid=0, wBusy=0.
  - cycle+3: IDLE.
- num_steps=3, out_ready low for 4 cycles while step=1 -> step and wSelec=table[1] stable for all 4 cycles; then step 2, done; 3 accepted handshakes total.
- num_steps=2, loop=1, out_ready=1 -> step sequence 0,1,0,1,...; abort at step=1 -> next cycle out_valid=0, wBusy=0, done never asserted, step stays 1.
- cfg_we during RUN -> cfg_err pulse, table entry unchanged on the next run; start with num_steps=0 or 9 -> cfg_err pulse, stays IDLE, out_valid=0.
- reset_L low for one cycle mid-RUN at step=2 -> outputs 0 asynchronously; after release, a start with num_steps=1 drives wSelec=0 (table cleared).
